z80_io_initiator: RTL and testbench
===================================

# z80_io_initiator

Bus-cycle generator that drives the Z80-style I/O port interface (address, `rd_iorq_n`/`wr_iorq_n` strobes, 8-bit data bus) as the initiating end. Its counterpart is the `cpu_io` responder in front of the VDP. An internal requester issues single read or write transactions through a req/busy/done handshake. The block sequences setup, strobe, hold and recovery phases with parameterised cycle counts and honours a `wait_n` stretch input. It serves as the host-side bus master for on-board self-test and for driving the VDP port map from an embedded controller.

## Interface
- `SETUP_CYCLES`, default 2: address/data setup before strobe falls; must be ≥1.
- `STROBE_CYCLES`, default 6: minimum strobe-low length; must be ≥2.
- `HOLD_CYCLES`, default 2: address/data hold after strobe rises; must be ≥1.
- `RECOVERY_CYCLES`, default 2: idle gap before `done`; must be ≥1.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: start a transaction; sampled only in IDLE.
- `wr` in 1: 1 selects write, 0 selects read; captured with `req`.
- `addr` in 8: port address; captured with `req`.
- `din` in 8: write data; captured with `req`.
- `dout` out 8: read data; held until the next read completes.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle completion pulse.
- `io_a` out 8: port address to the bus.
- `rd_iorq_n` out 1: read strobe, active low.
- `wr_iorq_n` out 1: write strobe, active low.
- `cd_out` out 8: bus data to drive.
- `cd_oe` out 1: enable for `cd_out`; the top level owns the tristate buffer.
- `cd_in` in 8: bus data sampled on reads.
- `wait_n` in 1: when low, stretches the strobe phase.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter is loaded on each state entry.
- IDLE:
  - `req`=1 captures `wr`, `addr` and `din`, then moves to SETUP.
  - `req`=0 stays in IDLE.
  - `req` outside IDLE is ignored; it is neither queued nor an error.
- SETUP: `io_a`=captured addr. For a write, `cd_oe`=1 and `cd_out`=din. Both strobes stay high. Lasts `SETUP_CYCLES`.
- STROBE: the selected strobe is low. Lasts `STROBE_CYCLES`.
  - If `wait_n`=0 is sampled on the final counted cycle, the block stays in STROBE until `wait_n`=1 is sampled.
  - `wait_n` has no effect in any other state.
  - On exit from a read, `cd_in` is registered into `dout` at the same edge that raises the strobe.
- HOLD: both strobes high. `io_a`, `cd_out` and `cd_oe` are unchanged. Lasts `HOLD_CYCLES`; `cd_oe` drops on exit.
- RECOVER: `io_a` holds its last value, `cd_oe`=0. Lasts `RECOVERY_CYCLES`. Exit goes to IDLE with `done`=1 for exactly that first IDLE cycle.
- In the `done` cycle `busy`=0. A new `req` in that cycle is accepted, giving back-to-back transactions with no extra gap.
- `rd_iorq_n` and `wr_iorq_n` are never low together, and both are high in every non-STROBE state.
- A write never changes `dout`.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0.
  - `rd_iorq_n`=1, `wr_iorq_n`=1.
  - `cd_oe`=0, `cd_out`=0, `io_a`=0, `dout`=0.
- Reset mid-transaction: at the next edge the strobes go high, `cd_oe`=0, `busy`=0, and no `done` is issued.
- All outputs are registered; none depends combinationally on an input.
- Latency: with `req` sampled at the end of cycle 0, `done`=1 in cycle 1+S+T+H+R+W, where W is the number of wait-stretch cycles. With the defaults and W=0, `done` is in cycle 13.
- Strobe low exactly T+W cycles. Address stable from S cycles before the strobe falls until H cycles after it rises.
- Counter width is `$clog2` of the largest parameter plus 1. Counters never wrap; the wait stretch is unbounded.

## Structure
- Package `z80_io_pkg` holds:
  - the `io_state_t` enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - the default timing constants;
  - the port-select constants 8'h98–8'h9B used by test sequences.
- No sub-module: the FSM, phase counter and capture registers sit in one module.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Write, defaults, addr=8'h99, din=8'hA5:
  - `wr_iorq_n` low cycles 3–8, `cd_oe` high cycles 1–10, `io_a`=8'h99 cycles 1–12.
  - `done` in cycle 13; `rd_iorq_n` never low.
- Read, addr=8'h98, `cd_in`=8'h3C during the strobe: `rd_iorq_n` low 6 cycles, `cd_oe` stays 0, `dout`=8'h3C in the `done` cycle and after.
- `wait_n` low for 4 cycles starting at the last strobe cycle: strobe low 10 cycles, `done` in cycle 17.
- `req` held high continuously: second transaction accepted in the `done` cycle, its SETUP starts in the next cycle, and `req` pulses during `busy` are ignored.
- `reset` asserted in the STROBE of a write: next cycle both strobes high, `cd_oe`=0, `busy`=0, no `done`.
- Parameters S=1, T=2, H=1, R=1: `done` in cycle 6 for a read, with `dout` correct.

Source files
------------

// File: rtl/z80_io_pkg.sv
// Shared types and constants for the Z80-style I/O port initiator.
package z80_io_pkg;

  localparam int unsigned DEF_SETUP_CYCLES    = 2;
  localparam int unsigned DEF_STROBE_CYCLES   = 6;
  localparam int unsigned DEF_HOLD_CYCLES     = 2;
  localparam int unsigned DEF_RECOVERY_CYCLES = 2;

  // VDP port map used by test sequences
  localparam logic [7:0] PORT_VRAM_DATA    = 8'h98;
  localparam logic [7:0] PORT_VDP_CTRL     = 8'h99;
  localparam logic [7:0] PORT_PALETTE      = 8'h9A;
  localparam logic [7:0] PORT_REG_INDIRECT = 8'h9B;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } io_state_t;

  function automatic int unsigned max4(input int unsigned a, b, c, d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/z80_io_initiator_if.sv
// Requester handshake plus Z80 I/O bus signals between initiator and its environment.
interface z80_io_initiator_if;
  logic       req;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic [7:0] io_a;
  logic       rd_iorq_n;
  logic       wr_iorq_n;
  logic [7:0] cd_out;
  logic       cd_oe;
  logic [7:0] cd_in;
  logic       wait_n;

  modport master (
    input  req, wr, addr, din, cd_in, wait_n,
    output dout, busy, done, io_a, rd_iorq_n, wr_iorq_n, cd_out, cd_oe
  );

  modport slave (
    output req, wr, addr, din, cd_in, wait_n,
    input  dout, busy, done, io_a, rd_iorq_n, wr_iorq_n, cd_out, cd_oe
  );
endinterface

// File: rtl/z80_io_initiator.sv
// Single-transaction Z80 I/O bus master: setup, strobe (wait-stretchable), hold, recovery.
module z80_io_initiator
  import z80_io_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES   = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
  input logic                clk,
  input logic                reset,
  z80_io_initiator_if.master bus
);

  localparam int unsigned MAX_CYC = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, RECOVERY_CYCLES);
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_SETUP   = SETUP;
  localparam logic [2:0] ST_STROBE  = STROBE;
  localparam logic [2:0] ST_HOLD    = HOLD;
  localparam logic [2:0] ST_RECOVER = RECOVER;

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("SETUP_CYCLES must be >= 1");
  end
  if (STROBE_CYCLES < 2) begin : g_bad_strobe
    $error("STROBE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (RECOVERY_CYCLES < 1) begin : g_bad_recovery
    $error("RECOVERY_CYCLES must be >= 1");
  end

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr_q, wr_nxt;
  logic [7:0]    io_a_q, io_a_nxt;
  logic [7:0]    cd_out_q, cd_out_nxt;
  logic          cd_oe_q, cd_oe_nxt;
  logic          rd_n_q, rd_n_nxt;
  logic          wr_n_q, wr_n_nxt;
  logic [7:0]    dout_q, dout_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          last;

  // State, phase counter and every output are registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      io_a_q   <= 8'h00;
      cd_out_q <= 8'h00;
      cd_oe_q  <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      dout_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr_q     <= wr_nxt;
      io_a_q   <= io_a_nxt;
      cd_out_q <= cd_out_nxt;
      cd_oe_q  <= cd_oe_nxt;
      rd_n_q   <= rd_n_nxt;
      wr_n_q   <= wr_n_nxt;
      dout_q   <= dout_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  assign last = (cnt == '0);

  // Next state; outputs are derived from the state being entered so they land registered
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wr_nxt     = wr_q;
    io_a_nxt   = io_a_q;
    cd_out_nxt = cd_out_q;
    dout_nxt   = dout_q;
    done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = CW'(SETUP_CYCLES - 1);
          wr_nxt    = bus.wr;
          io_a_nxt  = bus.addr;
          if (bus.wr) cd_out_nxt = bus.din;
        end
      end
      ST_SETUP: begin
        if (last) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = CW'(STROBE_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        // counter parks at zero while wait_n stretches the final cycle
        if (last) begin
          if (bus.wait_n) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CW'(HOLD_CYCLES - 1);
            if (!wr_q) dout_nxt = bus.cd_in;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (last) begin
          state_nxt = ST_RECOVER;
          cnt_nxt   = CW'(RECOVERY_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_RECOVER: begin
        if (last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt  = (state_nxt != ST_IDLE);
    cd_oe_nxt = wr_nxt && (state_nxt == ST_SETUP || state_nxt == ST_STROBE || state_nxt == ST_HOLD);
    rd_n_nxt  = !(state_nxt == ST_STROBE && !wr_nxt);
    wr_n_nxt  = !(state_nxt == ST_STROBE && wr_nxt);
  end

  assign bus.io_a      = io_a_q;
  assign bus.cd_out    = cd_out_q;
  assign bus.cd_oe     = cd_oe_q;
  assign bus.rd_iorq_n = rd_n_q;
  assign bus.wr_iorq_n = wr_n_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_z80_io_initiator.sv
// Directed bench for z80_io_initiator: default timing DUT plus a minimum-timing DUT.
module tb_z80_io_initiator;
  import z80_io_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z80_io_initiator_if bus();
  z80_io_initiator_if bus2();

  assign bus2.req    = bus.req;
  assign bus2.wr     = bus.wr;
  assign bus2.addr   = bus.addr;
  assign bus2.din    = bus.din;
  assign bus2.cd_in  = bus.cd_in;
  assign bus2.wait_n = bus.wait_n;

  z80_io_initiator u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  z80_io_initiator #(
    .SETUP_CYCLES    (1),
    .STROBE_CYCLES   (2),
    .HOLD_CYCLES     (1),
    .RECOVERY_CYCLES (1)
  ) u_dut_min (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       rd_lo [32];
  logic       wr_lo [32];
  logic       oe    [32];
  logic       dn    [32];
  logic       bsy   [32];
  logic [7:0] ioa   [32];
  logic [7:0] cdo   [32];
  logic [7:0] dq    [32];
  logic       dn2   [32];
  logic [7:0] dq2   [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_of(input logic v [32], input int lo, input int hi);
    int k = 0;
    for (int i = lo; i <= hi; i++) if (v[i] === 1'b1) k++;
    return k;
  endfunction

  function automatic int first_of(input logic v [32]);
    for (int i = 0; i < 32; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int last_of(input logic v [32]);
    for (int i = 31; i >= 0; i--) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic clear_rec();
    for (int i = 0; i < 32; i++) begin
      rd_lo[i] = 1'b0; wr_lo[i] = 1'b0; oe[i] = 1'b0; dn[i] = 1'b0; bsy[i] = 1'b0;
      ioa[i] = 8'h00; cdo[i] = 8'h00; dq[i] = 8'h00; dn2[i] = 1'b0; dq2[i] = 8'h00;
    end
  endtask

  task automatic sample(input int c);
    rd_lo[c] = ~bus.rd_iorq_n;
    wr_lo[c] = ~bus.wr_iorq_n;
    oe[c]    = bus.cd_oe;
    dn[c]    = bus.done;
    bsy[c]   = bus.busy;
    ioa[c]   = bus.io_a;
    cdo[c]   = bus.cd_out;
    dq[c]    = bus.dout;
    dn2[c]   = bus2.done;
    dq2[c]   = bus2.dout;
  endtask

  // Cycle 0 presents the request; later cycles carry junk addr/din/wr except at sw
  task automatic run_txn(input bit held, input logic w, input logic w2,
                         input logic [7:0] a, input logic [7:0] a2,
                         input logic [7:0] d, input logic [7:0] d2, input int sw,
                         input int ws, input int wl, input logic [7:0] cdv, input int ncyc);
    clear_rec();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      bus.req    = held ? 1'b1 : (c == 0);
      bus.wr     = (c == 0) ? w : (c == sw) ? w2 : ~w;
      bus.addr   = (c == 0) ? a : (c == sw) ? a2 : 8'h55;
      bus.din    = (c == 0) ? d : (c == sw) ? d2 : 8'hEE;
      bus.wait_n = !(c >= ws && c < ws + wl);
      bus.cd_in  = (held || (c >= 3 && c <= 8 + wl)) ? cdv : 8'hFF;
      @(negedge clk);
      sample(c);
    end
    @(posedge clk); #1;
    bus.req = 1'b0; bus.wait_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 8'h00; bus.din = 8'h00;
    bus.cd_in = 8'h00; bus.wait_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_rd_n",  32'(bus.rd_iorq_n), 32'd1);
    chk("rst_wr_n",  32'(bus.wr_iorq_n), 32'd1);
    chk("rst_cd_oe", 32'(bus.cd_oe), 32'd0);
    chk("rst_cd_out", 32'(bus.cd_out), 32'h00);
    chk("rst_io_a",  32'(bus.io_a), 32'h00);
    chk("rst_dout",  32'(bus.dout), 32'h00);
    @(posedge clk); #1 reset = 1'b0;

    // read, default timing
    run_txn(1'b0, 1'b0, 1'b0, PORT_VRAM_DATA, 8'h00, 8'h00, 8'h00, -1, -1, 0, 8'h3C, 16);
    chk("rd_strobe_len",   32'(count_of(rd_lo, 0, 15)), 32'd6);
    chk("rd_strobe_first", 32'(first_of(rd_lo)), 32'd3);
    chk("rd_no_wr_strobe", 32'(count_of(wr_lo, 0, 15)), 32'd0);
    chk("rd_no_oe",        32'(count_of(oe, 0, 15)), 32'd0);
    chk("rd_done_cycle",   32'(first_of(dn)), 32'd13);
    chk("rd_done_pulses",  32'(count_of(dn, 0, 15)), 32'd1);
    chk("rd_busy_len",     32'(count_of(bsy, 0, 15)), 32'd12);
    chk("rd_busy_c1",      32'(bsy[1]), 32'd1);
    chk("rd_io_a",         32'(ioa[5]), 32'h98);
    chk("rd_dout_pre",     32'(dq[8]), 32'h00);
    chk("rd_dout_edge",    32'(dq[9]), 32'h3C);
    chk("rd_dout_done",    32'(dq[13]), 32'h3C);
    chk("rd_dout_after",   32'(dq[15]), 32'h3C);
    chk("min_done_cycle",  32'(first_of(dn2)), 32'd6);
    chk("min_done_pulses", 32'(count_of(dn2, 0, 15)), 32'd1);
    chk("min_dout",        32'(dq2[6]), 32'h3C);

    // write, default timing
    run_txn(1'b0, 1'b1, 1'b1, PORT_VDP_CTRL, 8'h00, 8'hA5, 8'h00, -1, -1, 0, 8'h77, 16);
    chk("wr_strobe_first", 32'(first_of(wr_lo)), 32'd3);
    chk("wr_strobe_last",  32'(last_of(wr_lo)), 32'd8);
    chk("wr_strobe_len",   32'(count_of(wr_lo, 0, 15)), 32'd6);
    chk("wr_no_rd_strobe", 32'(count_of(rd_lo, 0, 15)), 32'd0);
    chk("wr_oe_first",     32'(first_of(oe)), 32'd1);
    chk("wr_oe_last",      32'(last_of(oe)), 32'd10);
    chk("wr_oe_len",       32'(count_of(oe, 0, 15)), 32'd10);
    k = 0;
    for (int i = 1; i <= 12; i++) if (ioa[i] == 8'h99) k++;
    chk("wr_io_a_stable",  32'(k), 32'd12);
    chk("wr_cd_out",       32'(cdo[1]), 32'hA5);
    chk("wr_done_cycle",   32'(first_of(dn)), 32'd13);
    chk("wr_done_pulses",  32'(count_of(dn, 0, 15)), 32'd1);
    chk("wr_dout_kept",    32'(dq[15]), 32'h3C);

    // read with wait_n low for cycles 8..11
    run_txn(1'b0, 1'b0, 1'b0, PORT_VRAM_DATA, 8'h00, 8'h00, 8'h00, -1, 8, 4, 8'h5A, 22);
    chk("wt_strobe_len",   32'(count_of(rd_lo, 0, 21)), 32'd10);
    chk("wt_strobe_last",  32'(last_of(rd_lo)), 32'd12);
    chk("wt_done_cycle",   32'(first_of(dn)), 32'd17);
    chk("wt_dout",         32'(dq[17]), 32'h5A);

    // req held high: write to 9A, then read from 9B accepted in the done cycle
    run_txn(1'b1, 1'b1, 1'b0, PORT_PALETTE, PORT_REG_INDIRECT, 8'h11, 8'h22, 13, -1, 0, 8'hC3, 28);
    chk("b2b_done_first",  32'(first_of(dn)), 32'd13);
    chk("b2b_done_last",   32'(last_of(dn)), 32'd26);
    chk("b2b_done_pulses", 32'(count_of(dn, 0, 27)), 32'd2);
    chk("b2b_busy_c13",    32'(bsy[13]), 32'd0);
    chk("b2b_busy_c14",    32'(bsy[14]), 32'd1);
    chk("b2b_io_a_first",  32'(ioa[5]), 32'h9A);
    chk("b2b_io_a_second", 32'(ioa[14]), 32'h9B);
    chk("b2b_wr_len",      32'(count_of(wr_lo, 0, 27)), 32'd6);
    chk("b2b_rd_first",    32'(first_of(rd_lo)), 32'd16);
    chk("b2b_dout",        32'(dq[22]), 32'hC3);

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    // reset asserted during the strobe of a write
    clear_rec();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.req  = (c == 0);
      bus.wr   = 1'b1;
      bus.addr = PORT_PALETTE;
      bus.din  = 8'h5C;
      reset    = (c == 5);
      @(negedge clk);
      sample(c);
    end
    chk("rmid_strobe_pre", 32'(wr_lo[5]), 32'd1);
    chk("rmid_wr_n",       32'(wr_lo[6]), 32'd0);
    chk("rmid_rd_n",       32'(rd_lo[6]), 32'd0);
    chk("rmid_cd_oe",      32'(oe[6]), 32'd0);
    chk("rmid_busy",       32'(bsy[6]), 32'd0);
    chk("rmid_no_done",    32'(count_of(dn, 0, 19)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
